// File: rtl/alu_req_arbiter_if.sv
// Requester-side and ALU-core-side signal bundle for alu_req_arbiter.
// master: the arbiter's view; slave: the requesters plus the ALU core.
interface alu_req_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req_valid;
  logic [32*N_REQ-1:0] req_A;
  logic [32*N_REQ-1:0] req_B;
  logic [8*N_REQ-1:0]  req_op;
  logic [N_REQ-1:0]    req_op_pf;
  logic [N_REQ-1:0]    req_sv;
  logic [N_REQ-1:0]    req_ack;
  logic [N_REQ-1:0]    rsp_valid;
  logic [63:0]         rsp_result;
  logic [5:0]          rsp_err;
  logic                rsp_gp;
  logic                rsp_tmo;
  logic                alu_start;
  logic [31:0]         alu_A;
  logic [31:0]         alu_B;
  logic [7:0]          alu_op;
  logic                alu_op_pf;
  logic                alu_sv;
  logic                alu_done;
  logic [63:0]         alu_result;
  logic [5:0]          alu_err;
  logic                alu_gp;
  logic                busy;

  modport master (
    input  req_valid, req_A, req_B, req_op, req_op_pf, req_sv,
    input  alu_done, alu_result, alu_err, alu_gp,
    output req_ack, rsp_valid, rsp_result, rsp_err, rsp_gp, rsp_tmo,
    output alu_start, alu_A, alu_B, alu_op, alu_op_pf, alu_sv, busy
  );

  modport slave (
    output req_valid, req_A, req_B, req_op, req_op_pf, req_sv,
    output alu_done, alu_result, alu_err, alu_gp,
    input  req_ack, rsp_valid, rsp_result, rsp_err, rsp_gp, rsp_tmo,
    input  alu_start, alu_A, alu_B, alu_op, alu_op_pf, alu_sv, busy
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one tinyALU core among N_REQ requesters.
// Optional WAIT-state watchdog enabled by defining ARB_TIMEOUT_EN.
module alu_req_arbiter #(
  parameter int N_REQ       = 4,
  parameter int IDX_W       = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  alu_req_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [N_REQ-1:0] ONE_HOT_0 = N_REQ'(1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   last_grant_reg, last_grant_next;
  logic [N_REQ-1:0]   req_ack_reg, req_ack_next;
  logic [N_REQ-1:0]   rsp_valid_reg, rsp_valid_next;
  logic [63:0]        rsp_result_reg, rsp_result_next;
  logic [5:0]         rsp_err_reg, rsp_err_next;
  logic               rsp_gp_reg, rsp_gp_next;
  logic               rsp_tmo_reg, rsp_tmo_next;
  logic               alu_start_reg, alu_start_next;
  logic [31:0]        alu_a_reg, alu_a_next;
  logic [31:0]        alu_b_reg, alu_b_next;
  logic [7:0]         alu_op_reg, alu_op_next;
  logic               alu_op_pf_reg, alu_op_pf_next;
  logic               alu_sv_reg, alu_sv_next;
  logic               busy_reg, busy_next;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0]         tmo_cnt_reg, tmo_cnt_next;
`else
  logic               unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

  logic [31:0]        req_a_arr  [N_REQ];
  logic [31:0]        req_b_arr  [N_REQ];
  logic [7:0]         req_op_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_a_arr[gi]  = bus.req_A[gi*32 +: 32];
      assign req_b_arr[gi]  = bus.req_B[gi*32 +: 32];
      assign req_op_arr[gi] = bus.req_op[gi*8 +: 8];
    end
  endgenerate

  // Winner is the valid requester at the smallest rotational distance after last_grant.
  logic [IDX_W-1:0]   winner;
  logic               winner_found;
  int                 rr_dist;
  int                 rr_best;

  always_comb begin
    winner       = last_grant_reg;
    winner_found = 1'b0;
    rr_dist      = 0;
    rr_best      = N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      rr_dist = (i + N_REQ - 1 - int'(last_grant_reg)) % N_REQ;
      if (bus.req_valid[i] && (rr_dist < rr_best)) begin
        rr_best      = rr_dist;
        winner       = IDX_W'(i);
        winner_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    req_ack_next    = '0;
    rsp_valid_next  = '0;
    rsp_result_next = rsp_result_reg;
    rsp_err_next    = rsp_err_reg;
    rsp_gp_next     = rsp_gp_reg;
    rsp_tmo_next    = rsp_tmo_reg;
    alu_start_next  = 1'b0;
    alu_a_next      = alu_a_reg;
    alu_b_next      = alu_b_reg;
    alu_op_next     = alu_op_reg;
    alu_op_pf_next  = alu_op_pf_reg;
    alu_sv_next     = alu_sv_reg;
`ifdef ARB_TIMEOUT_EN
    tmo_cnt_next    = tmo_cnt_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (winner_found) begin
          alu_a_next      = req_a_arr[winner];
          alu_b_next      = req_b_arr[winner];
          alu_op_next     = req_op_arr[winner];
          alu_op_pf_next  = bus.req_op_pf[winner];
          alu_sv_next     = bus.req_sv[winner];
          req_ack_next    = ONE_HOT_0 << winner;
          last_grant_next = winner;
          alu_start_next  = 1'b1;
          state_next      = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        state_next = ST_WAIT;
`ifdef ARB_TIMEOUT_EN
        tmo_cnt_next = '0;
`endif
      end

      ST_WAIT: begin
        // A done coinciding with the watchdog expiry is treated as a normal response.
        if (bus.alu_done) begin
          rsp_result_next = bus.alu_result;
          rsp_err_next    = bus.alu_err;
          rsp_gp_next     = bus.alu_gp;
          rsp_tmo_next    = 1'b0;
          rsp_valid_next  = ONE_HOT_0 << last_grant_reg;
          state_next      = ST_RESP;
        end
`ifdef ARB_TIMEOUT_EN
        else if (tmo_cnt_reg == TMO_LAST) begin
          rsp_result_next = '0;
          rsp_err_next    = '0;
          rsp_gp_next     = 1'b1;
          rsp_tmo_next    = 1'b1;
          rsp_valid_next  = ONE_HOT_0 << last_grant_reg;
          state_next      = ST_RESP;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 8'd1;
        end
`endif
      end

      ST_RESP: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= LAST_IDX;
      req_ack_reg    <= '0;
      rsp_valid_reg  <= '0;
      rsp_result_reg <= '0;
      rsp_err_reg    <= '0;
      rsp_gp_reg     <= 1'b0;
      rsp_tmo_reg    <= 1'b0;
      alu_start_reg  <= 1'b0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_op_reg     <= '0;
      alu_op_pf_reg  <= 1'b0;
      alu_sv_reg     <= 1'b0;
      busy_reg       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt_reg    <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      req_ack_reg    <= req_ack_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_result_reg <= rsp_result_next;
      rsp_err_reg    <= rsp_err_next;
      rsp_gp_reg     <= rsp_gp_next;
      rsp_tmo_reg    <= rsp_tmo_next;
      alu_start_reg  <= alu_start_next;
      alu_a_reg      <= alu_a_next;
      alu_b_reg      <= alu_b_next;
      alu_op_reg     <= alu_op_next;
      alu_op_pf_reg  <= alu_op_pf_next;
      alu_sv_reg     <= alu_sv_next;
      busy_reg       <= busy_next;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt_reg    <= tmo_cnt_next;
`endif
    end
  end

  assign bus.req_ack    = req_ack_reg;
  assign bus.rsp_valid  = rsp_valid_reg;
  assign bus.rsp_result = rsp_result_reg;
  assign bus.rsp_err    = rsp_err_reg;
  assign bus.rsp_gp     = rsp_gp_reg;
  assign bus.rsp_tmo    = rsp_tmo_reg;
  assign bus.alu_start  = alu_start_reg;
  assign bus.alu_A      = alu_a_reg;
  assign bus.alu_B      = alu_b_reg;
  assign bus.alu_op     = alu_op_reg;
  assign bus.alu_op_pf  = alu_op_pf_reg;
  assign bus.alu_sv     = alu_sv_reg;
  assign bus.busy       = busy_reg;

endmodule
